// File: rtl/pi_route_decode_pkg.sv
// Shared definitions for the pi-switch route decoder and arbiter: direction codes,
// pi select codes, default arbiter latency and the packet address extractor.
package pi_route_decode_pkg;

  typedef enum logic [1:0] {
    DIR_VOID  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ROLE_L  = 2'd0,
    ROLE_R  = 2'd1,
    ROLE_UL = 2'd2,
    ROLE_UR = 2'd3
  } port_role_t;

  localparam logic [1:0] UPL = 2'b11;
  localparam logic [1:0] UPR = 2'b00;

  localparam int DEFAULT_ARB_LAT = 5;
  localparam int MAX_PKT_BITS    = 256;
  localparam int MAX_ADDR_BITS   = 32;

  // Address sits just below the valid flag at the top of the packet.
  function automatic logic [MAX_ADDR_BITS-1:0] pkt_addr(input logic [MAX_PKT_BITS-1:0] pkt,
                                                        input int pkt_bits,
                                                        input int addr_bits);
    return MAX_ADDR_BITS'((pkt >> (pkt_bits - 1 - addr_bits)) &
                          ((MAX_PKT_BITS'(1) << addr_bits) - MAX_PKT_BITS'(1)));
  endfunction

endpackage

// File: rtl/pi_route_decode_port.sv
// One port of the pi-switch route decoder: direction decode, packet delay line and,
// when PI_ROUTE_STATS_EN is defined, saturating traffic/turnback counters.
module pi_route_port
  import pi_route_decode_pkg::*;
#(
  parameter int         PACKET_BITS = 49,
  parameter int         ADDR_BITS   = 8,
  parameter int         LEVEL       = 1,
  parameter int         POS         = 0,
  parameter int         ARB_LAT     = DEFAULT_ARB_LAT,
  parameter port_role_t ROLE        = ROLE_L
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt,
  output logic [1:0]             d,
  output logic [PACKET_BITS-1:0] pkt_dly
`ifdef PI_ROUTE_STATS_EN
  ,
  output logic [15:0]            stat_valid,
  output logic [15:0]            stat_turn
`endif
);

  logic [ADDR_BITS-1:0]   addr;
  logic                   match;
  logic [1:0]             dir_next;
  logic [1:0]             d_reg;
  logic [PACKET_BITS-1:0] stage_reg [ARB_LAT+1];

  assign addr = ADDR_BITS'(pkt_addr(MAX_PKT_BITS'(pkt), PACKET_BITS, ADDR_BITS));

  // The root switch owns the whole address space.
  if (LEVEL == ADDR_BITS) begin : g_root
    assign match = 1'b1;
  end else begin : g_sub
    assign match = (addr[ADDR_BITS-1:LEVEL] == (ADDR_BITS-LEVEL)'(POS));
  end

  always_comb begin
    dir_next = DIR_VOID;
    if (pkt[PACKET_BITS-1]) begin
      if (!match)
        dir_next = DIR_UP;
      else if (addr[LEVEL-1])
        dir_next = DIR_RIGHT;
      else
        dir_next = DIR_LEFT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_reg <= DIR_VOID;
      for (int i = 0; i <= ARB_LAT; i++) stage_reg[i] <= '0;
    end else begin
      d_reg        <= dir_next;
      stage_reg[0] <= pkt;
      for (int i = 1; i <= ARB_LAT; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign d       = d_reg;
  assign pkt_dly = stage_reg[ARB_LAT];

`ifdef PI_ROUTE_STATS_EN
  logic        turn;
  logic [15:0] stat_valid_reg;
  logic [15:0] stat_turn_reg;

  // A turnback is a packet leaving through the side it arrived on.
  always_comb begin
    turn = 1'b0;
    case (ROLE)
      ROLE_L:  turn = (d_reg == DIR_LEFT);
      ROLE_R:  turn = (d_reg == DIR_RIGHT);
      default: turn = (d_reg == DIR_UP);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_valid_reg <= '0;
      stat_turn_reg  <= '0;
    end else begin
      if (d_reg != DIR_VOID && stat_valid_reg != 16'hFFFF)
        stat_valid_reg <= stat_valid_reg + 16'd1;
      if (turn && stat_turn_reg != 16'hFFFF)
        stat_turn_reg <= stat_turn_reg + 16'd1;
    end
  end

  assign stat_valid = stat_valid_reg;
  assign stat_turn  = stat_turn_reg;
`endif

endmodule

// File: rtl/pi_route_decode.sv
// Route decoder for one pi switch: four identical ports differing only in turnback rule.
// Optional counters are built when PI_ROUTE_STATS_EN is defined.
module pi_route_decode
  import pi_route_decode_pkg::*;
#(
  parameter int PACKET_BITS = 49,
  parameter int ADDR_BITS   = 8,
  parameter int LEVEL       = 1,
  parameter int POS         = 0,
  parameter int ARB_LAT     = DEFAULT_ARB_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt_l,
  input  logic [PACKET_BITS-1:0] pkt_r,
  input  logic [PACKET_BITS-1:0] pkt_ul,
  input  logic [PACKET_BITS-1:0] pkt_ur,
  output logic [1:0]             d_l,
  output logic [1:0]             d_r,
  output logic [1:0]             d_ul,
  output logic [1:0]             d_ur,
  output logic [PACKET_BITS-1:0] pkt_l_dly,
  output logic [PACKET_BITS-1:0] pkt_r_dly,
  output logic [PACKET_BITS-1:0] pkt_ul_dly,
  output logic [PACKET_BITS-1:0] pkt_ur_dly
`ifdef PI_ROUTE_STATS_EN
  ,
  output logic [15:0]            stat_valid_l,
  output logic [15:0]            stat_valid_r,
  output logic [15:0]            stat_valid_ul,
  output logic [15:0]            stat_valid_ur,
  output logic [15:0]            stat_turn_l,
  output logic [15:0]            stat_turn_r,
  output logic [15:0]            stat_turn_ul,
  output logic [15:0]            stat_turn_ur
`endif
);

  pi_route_port #(.PACKET_BITS(PACKET_BITS), .ADDR_BITS(ADDR_BITS), .LEVEL(LEVEL), .POS(POS),
                  .ARB_LAT(ARB_LAT), .ROLE(ROLE_L)) u_port_l (
    .clk(clk), .reset(reset), .pkt(pkt_l), .d(d_l), .pkt_dly(pkt_l_dly)
`ifdef PI_ROUTE_STATS_EN
    , .stat_valid(stat_valid_l), .stat_turn(stat_turn_l)
`endif
  );

  pi_route_port #(.PACKET_BITS(PACKET_BITS), .ADDR_BITS(ADDR_BITS), .LEVEL(LEVEL), .POS(POS),
                  .ARB_LAT(ARB_LAT), .ROLE(ROLE_R)) u_port_r (
    .clk(clk), .reset(reset), .pkt(pkt_r), .d(d_r), .pkt_dly(pkt_r_dly)
`ifdef PI_ROUTE_STATS_EN
    , .stat_valid(stat_valid_r), .stat_turn(stat_turn_r)
`endif
  );

  pi_route_port #(.PACKET_BITS(PACKET_BITS), .ADDR_BITS(ADDR_BITS), .LEVEL(LEVEL), .POS(POS),
                  .ARB_LAT(ARB_LAT), .ROLE(ROLE_UL)) u_port_ul (
    .clk(clk), .reset(reset), .pkt(pkt_ul), .d(d_ul), .pkt_dly(pkt_ul_dly)
`ifdef PI_ROUTE_STATS_EN
    , .stat_valid(stat_valid_ul), .stat_turn(stat_turn_ul)
`endif
  );

  pi_route_port #(.PACKET_BITS(PACKET_BITS), .ADDR_BITS(ADDR_BITS), .LEVEL(LEVEL), .POS(POS),
                  .ARB_LAT(ARB_LAT), .ROLE(ROLE_UR)) u_port_ur (
    .clk(clk), .reset(reset), .pkt(pkt_ur), .d(d_ur), .pkt_dly(pkt_ur_dly)
`ifdef PI_ROUTE_STATS_EN
    , .stat_valid(stat_valid_ur), .stat_turn(stat_turn_ur)
`endif
  );

endmodule

// File: tb/tb_pi_route_decode.sv
// Bench for pi_route_decode: three configurations (level 1, root, level 3 pos 5) share inputs;
// a history-based model predicts directions, delayed packets and (if enabled) counters.
module tb_pi_route_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [48:0] in_pkt [4];

  logic [1:0]  a_d [4];
  logic [48:0] a_dly [4];
  logic [1:0]  b_d [4];
  logic [48:0] b_dly [4];
  logic [1:0]  c_d [4];
  logic [48:0] c_dly [4];
`ifdef PI_ROUTE_STATS_EN
  logic [15:0] a_sv [4];
  logic [15:0] a_st [4];
  logic [15:0] b_sv [4];
  logic [15:0] b_st [4];
  logic [15:0] c_sv [4];
  logic [15:0] c_st [4];
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Model state: hist[p][k] is the input accepted k+1 edges ago (zero if before reset release).
  logic [48:0] hist [4][6];
  int          cnt_v [4];
  int          cnt_t [4];

  always #5 clk = ~clk;

  pi_route_decode #(.PACKET_BITS(49), .ADDR_BITS(8), .LEVEL(1), .POS(0), .ARB_LAT(5)) dut_a (
    .clk(clk), .reset(reset),
    .pkt_l(in_pkt[0]), .pkt_r(in_pkt[1]), .pkt_ul(in_pkt[2]), .pkt_ur(in_pkt[3]),
    .d_l(a_d[0]), .d_r(a_d[1]), .d_ul(a_d[2]), .d_ur(a_d[3]),
    .pkt_l_dly(a_dly[0]), .pkt_r_dly(a_dly[1]), .pkt_ul_dly(a_dly[2]), .pkt_ur_dly(a_dly[3])
`ifdef PI_ROUTE_STATS_EN
    , .stat_valid_l(a_sv[0]), .stat_valid_r(a_sv[1]), .stat_valid_ul(a_sv[2]), .stat_valid_ur(a_sv[3])
    , .stat_turn_l(a_st[0]), .stat_turn_r(a_st[1]), .stat_turn_ul(a_st[2]), .stat_turn_ur(a_st[3])
`endif
  );

  pi_route_decode #(.PACKET_BITS(49), .ADDR_BITS(8), .LEVEL(8), .POS(0), .ARB_LAT(5)) dut_b (
    .clk(clk), .reset(reset),
    .pkt_l(in_pkt[0]), .pkt_r(in_pkt[1]), .pkt_ul(in_pkt[2]), .pkt_ur(in_pkt[3]),
    .d_l(b_d[0]), .d_r(b_d[1]), .d_ul(b_d[2]), .d_ur(b_d[3]),
    .pkt_l_dly(b_dly[0]), .pkt_r_dly(b_dly[1]), .pkt_ul_dly(b_dly[2]), .pkt_ur_dly(b_dly[3])
`ifdef PI_ROUTE_STATS_EN
    , .stat_valid_l(b_sv[0]), .stat_valid_r(b_sv[1]), .stat_valid_ul(b_sv[2]), .stat_valid_ur(b_sv[3])
    , .stat_turn_l(b_st[0]), .stat_turn_r(b_st[1]), .stat_turn_ul(b_st[2]), .stat_turn_ur(b_st[3])
`endif
  );

  pi_route_decode #(.PACKET_BITS(49), .ADDR_BITS(8), .LEVEL(3), .POS(5), .ARB_LAT(5)) dut_c (
    .clk(clk), .reset(reset),
    .pkt_l(in_pkt[0]), .pkt_r(in_pkt[1]), .pkt_ul(in_pkt[2]), .pkt_ur(in_pkt[3]),
    .d_l(c_d[0]), .d_r(c_d[1]), .d_ul(c_d[2]), .d_ur(c_d[3]),
    .pkt_l_dly(c_dly[0]), .pkt_r_dly(c_dly[1]), .pkt_ul_dly(c_dly[2]), .pkt_ur_dly(c_dly[3])
`ifdef PI_ROUTE_STATS_EN
    , .stat_valid_l(c_sv[0]), .stat_valid_r(c_sv[1]), .stat_valid_ul(c_sv[2]), .stat_valid_ur(c_sv[3])
    , .stat_turn_l(c_st[0]), .stat_turn_r(c_st[1]), .stat_turn_ul(c_st[2]), .stat_turn_ur(c_st[3])
`endif
  );

  function automatic logic [48:0] mk(input bit v, input logic [7:0] a, input logic [39:0] pl);
    return {v, a, pl};
  endfunction

  // Direction from the routing rules: inside subtree -> LEFT/RIGHT by bit LEVEL-1, else UP.
  function automatic logic [1:0] ref_dir(input logic [48:0] p, input int level, input int pos);
    int addr;
    addr = int'(p[47:40]);
    if (!p[48]) return 2'd0;
    if (level == 8 || (addr >> level) == pos)
      return (((addr >> (level - 1)) & 1) == 1) ? 2'd2 : 2'd1;
    return 2'd3;
  endfunction

  function automatic bit is_turn(input int port, input logic [1:0] dir);
    if (port == 0) return dir == 2'd1;
    if (port == 1) return dir == 2'd2;
    return dir == 2'd3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 6; s++) hist[p][s] = '0;
      cnt_v[p] = 0;
      cnt_t[p] = 0;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("a_d[%0d]", p), 64'(a_d[p]), 64'(ref_dir(hist[p][0], 1, 0)));
      chk($sformatf("b_d[%0d]", p), 64'(b_d[p]), 64'(ref_dir(hist[p][0], 8, 0)));
      chk($sformatf("c_d[%0d]", p), 64'(c_d[p]), 64'(ref_dir(hist[p][0], 3, 5)));
      chk($sformatf("a_dly[%0d]", p), 64'(a_dly[p]), 64'(hist[p][5]));
      chk($sformatf("c_dly[%0d]", p), 64'(c_dly[p]), 64'(hist[p][5]));
`ifdef PI_ROUTE_STATS_EN
      chk($sformatf("stat_valid[%0d]", p), 64'(a_sv[p]), 64'(cnt_v[p]));
      chk($sformatf("stat_turn[%0d]", p), 64'(a_st[p]), 64'(cnt_t[p]));
`endif
    end
  endtask

  task automatic tick(input bit do_check);
    @(posedge clk);
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        if (hist[p][0][48] && cnt_v[p] < 65535) cnt_v[p]++;
        if (is_turn(p, ref_dir(hist[p][0], 1, 0)) && cnt_t[p] < 65535) cnt_t[p]++;
        for (int s = 5; s > 0; s--) hist[p][s] = hist[p][s-1];
        hist[p][0] = in_pkt[p];
      end
    end
    #1;
    if (do_check) check_all();
  endtask

  function automatic logic [48:0] rnd_pkt();
    logic [7:0] a;
    case ($urandom % 4)
      0:       a = 8'($urandom_range(40, 47));
      1:       a = 8'($urandom_range(0, 1));
      default: a = 8'($urandom);
    endcase
    return mk(($urandom % 4) != 0, a, 40'({$urandom(), $urandom()}));
  endfunction

  typedef struct {
    logic [3:0][48:0] p;
    logic [3:0][1:0]  exp_a;
    logic [1:0]       exp_b_l;
  } vec_t;

  function automatic vec_t mkvec(input logic [48:0] l, input logic [48:0] r, input logic [48:0] ul,
                                 input logic [48:0] ur, input logic [1:0] el, input logic [1:0] er,
                                 input logic [1:0] eul, input logic [1:0] eur, input logic [1:0] eb);
    vec_t v;
    v.p[0] = l; v.p[1] = r; v.p[2] = ul; v.p[3] = ur;
    v.exp_a[0] = el; v.exp_a[1] = er; v.exp_a[2] = eul; v.exp_a[3] = eur;
    v.exp_b_l = eb;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   lat;

    // Hand-derived expectations for LEVEL=1 POS=0 (dut_a) and the root (dut_b, pkt_l only).
    vecs[0] = mkvec('0, '0, '0, '0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    vecs[1] = mkvec(mk(1, 8'h01, 40'h12345), '0, '0, '0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1);
    vecs[2] = mkvec('0, '0, mk(1, 8'h00, 40'h1), mk(1, 8'h04, 40'h2), 2'd0, 2'd0, 2'd1, 2'd3, 2'd0);
    vecs[3] = mkvec(mk(1, 8'h80, 40'hABC), '0, '0, '0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2);
    vecs[4] = mkvec(mk(0, 8'hFF, 40'hFFFFFFFFFF), mk(1, 8'h00, 40'h0), '0, '0,
                    2'd0, 2'd1, 2'd0, 2'd0, 2'd0);
    vecs[5] = mkvec(mk(1, 8'h00, 40'h5), mk(1, 8'h01, 40'h6), mk(1, 8'hFE, 40'h7), mk(1, 8'h01, 40'h8),
                    2'd1, 2'd2, 2'd3, 2'd2, 2'd1);

    reset = 1'b0;
    for (int p = 0; p < 4; p++) in_pkt[p] = '0;
    model_clear();
    #1;
    check_all();
    repeat (3) tick(1);
    #2 reset = 1'b1;
    repeat (2) tick(1);

    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 4; p++) in_pkt[p] = vecs[k].p[p];
      tick(1);
      for (int p = 0; p < 4; p++)
        chk($sformatf("vec%0d_d[%0d]", k, p), 64'(a_d[p]), 64'(vecs[k].exp_a[p]));
      chk($sformatf("vec%0d_root_d_l", k), 64'(b_d[0]), 64'(vecs[k].exp_b_l));
    end
    for (int p = 0; p < 4; p++) in_pkt[p] = '0;
    repeat (8) tick(1);

    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 4; p++) in_pkt[p] = rnd_pkt();
      tick(1);
    end

    // Reset mid-burst: outputs must clear before the next clock edge.
    for (int n = 0; n < 10; n++) begin
      for (int p = 0; p < 4; p++) in_pkt[p] = mk(1, 8'($urandom_range(0, 1)), 40'($urandom));
      tick(1);
    end
    #2 reset = 1'b0;
    model_clear();
    #1;
    check_all();
    repeat (2) tick(1);
    #2 reset = 1'b1;
    in_pkt[0] = mk(1, 8'h01, 40'hCAFE);
    for (int p = 1; p < 4; p++) in_pkt[p] = '0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (a_dly[0][48] === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("post_reset_latency", 64'(lat), 64'd6);
    in_pkt[0] = '0;
    repeat (8) tick(1);

`ifdef PI_ROUTE_STATS_EN
    in_pkt[0] = mk(1, 8'h00, 40'h77);
    repeat (70000) tick(0);
    tick(1);
    chk("sat_stat_valid_l", 64'(a_sv[0]), 64'hFFFF);
    chk("sat_stat_turn_l", 64'(a_st[0]), 64'hFFFF);
    in_pkt[0] = '0;
    repeat (3) tick(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pi_route_decode.md
# pi_route_decode

Upstream companion of the pi-switch arbiter in the butterfly-fat-tree (BFT) network. It takes the four packet inputs of one pi switch (left, right, up-left, up-right) and, one cycle later, registers a 2-bit direction request per port (VOID/LEFT/RIGHT/UP) for the arbiter. It also delays each packet so that it reaches the switch crossbar in the same cycle as the arbiter's select outputs. Optional per-port traffic counters are provided for bring-up.

## Interface
Parameters:
- `PACKET_BITS`, 49: packet width. Bit `[PACKET_BITS-1]` is the valid flag; the next `ADDR_BITS` bits down are the destination leaf address.
- `ADDR_BITS`, 8: leaf address width.
- `LEVEL`, 1: tree level of this switch, range 1..`ADDR_BITS`.
- `POS`, 0: index of this switch's subtree at `LEVEL`.
- `ARB_LAT`, 5: arbiter latency in cycles, from direction request to select.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: **asynchronous, active-low** reset.
- `pkt_l`, `pkt_r`, `pkt_ul`, `pkt_ur`, in, `PACKET_BITS` each: incoming packets.
- `d_l`, `d_r`, `d_ul`, `d_ur`, out, 2 each: registered direction requests to the arbiter.
- `pkt_l_dly`, `pkt_r_dly`, `pkt_ul_dly`, `pkt_ur_dly`, out, `PACKET_BITS` each: aligned packets to the crossbar.
- `stat_valid_[l|r|ul|ur]`, out, 16 each: only when `PI_ROUTE_STATS_EN` is defined.
- `stat_turn_[l|r|ul|ur]`, out, 16 each: only when `PI_ROUTE_STATS_EN` is defined.

## Operation
- Subtree match: the packet is inside this switch's subtree when `addr[ADDR_BITS-1:LEVEL] == POS`. When `LEVEL == ADDR_BITS` the match is always true (root switch).
- Per-port decode, applied identically to all four ports:
  - valid = 0 → VOID (2'b00), regardless of address bits.
  - valid = 1, match, `addr[LEVEL-1] == 0` → LEFT (2'b01).
  - valid = 1, match, `addr[LEVEL-1] == 1` → RIGHT (2'b10).
  - valid = 1, no match → UP (2'b11).
- Turnback events, counted only when stats are enabled:
  - `pkt_l` decoded LEFT.
  - `pkt_r` decoded RIGHT.
  - `pkt_ul` or `pkt_ur` decoded UP.
- Delay line:
  - Each port has a shift register of depth `1 + ARB_LAT` that carries the full packet unmodified.
  - The valid bit travels with the data.
- No backpressure. The network deflects, so every cycle accepts new input.

## Timing
- Direction latency is 1 cycle: `pkt_*` at edge N appears as `d_*` after edge N+1.
- Packet latency is `1 + ARB_LAT` cycles (6 by default). This equals the direction latency plus the arbiter latency, so `pkt_*_dly` and the arbiter's `sel_*` are cycle-aligned.
- Reset asserted (`reset` = 0), at any time including mid-stream:
  - All `d_*` go to VOID immediately.
  - Every delay stage clears to all-zero, so invalid packets come out.
  - Counters clear to 0.
- First cycle after reset deassertion:
  - `pkt_*_dly` stays zero for `1 + ARB_LAT` cycles, then shows the live stream.
  - Any packets in flight when reset asserted are dropped. This is intended.
- Counters:
  - 16-bit, saturate at 16'hFFFF with no wrap.
  - Increment on the registered decode, i.e. 1 cycle after input.
  - A valid turnback packet increments both its `stat_valid` and `stat_turn` counters in the same cycle.

## Configuration
- `PI_ROUTE_STATS_EN` defined: the eight counters and their output ports exist.
- `PI_ROUTE_STATS_EN` undefined: no counter logic and no stat ports. Decode and delay behaviour are unchanged.

## Structure
- Shared package (also used by the arbiter):
  - Direction codes VOID/LEFT/RIGHT/UP.
  - Pi select codes UPL = 2'b11, UPR = 2'b00.
  - Default `ARB_LAT` constant.
  - Function extracting the address field from a packet.
- One natural sub-module, `pi_route_port`:
  - Contains the decode, delay line and optional counters for one port.
  - Instantiated four times, with a port-role parameter that selects the turnback rule.

## Test plan
- Reset with `LEVEL`=1, `POS`=0, `ADDR_BITS`=8, then all inputs invalid → all `d_*` = VOID; all `pkt_*_dly` = 0 forever.
- `pkt_l` valid, addr 8'h01 → `d_l` = RIGHT one cycle later; `pkt_l_dly` equals the input exactly 6 cycles later.
- `pkt_ul` valid addr 8'h00; `pkt_ur` valid addr 8'h04 → `d_ul` = LEFT, `d_ur` = UP; `stat_turn_ur` increments 0→1.
- Root config `LEVEL`=8, `POS`=0, any valid address → never UP; addr 8'h80 → RIGHT.
- Stream 70000 valid LEFT packets on `pkt_l` → `stat_valid_l` and `stat_turn_l` hold at 16'hFFFF.
- Assert `reset` during a burst → outputs clear asynchronously before the next edge; after release the first valid `pkt_*_dly` appears exactly 6 cycles after the first post-reset input.
